// File: rtl/macro_ctrl.sv
// macro_ctrl: command sequencer for a compute-in-memory macro (weight load, readback, compute).
module macro_ctrl #(
  parameter int ROWS = 64,
  parameter int MAC_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [5:0]   cmd_addr,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [31:0]  w_data,
  input  logic [255:0] act_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [1:0]   res_op,
  output logic [111:0] res_data,
  output logic         busy,
  output logic         err,
  output logic         m_STDW,
  output logic         m_STDR,
  output logic [5:0]   m_STD_A,
  output logic [31:0]  m_weight_in,
  output logic [255:0] m_act_in,
  input  logic [31:0]  m_weight_out,
  input  logic [111:0] m_PSUM
);
  typedef enum logic [2:0] {IDLE, LOAD, RBACK, COMP, OUT} state_t;
  state_t state_q;
  logic [5:0] row_q, addr_q;
  logic [3:0] lat_q;
  logic stdw_q, stdr_q, err_q;
  logic [31:0] wdata_q;
  logic [255:0] act_q;
  logic [111:0] res_data_q;
  logic [1:0] res_op_q;
  logic accept, w_hs, last_row;
  assign accept = cmd_valid && state_q == IDLE;
  assign w_hs = w_valid && state_q == LOAD;
  assign last_row = row_q == 6'(ROWS - 1);
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign w_ready = state_q == LOAD;
  assign res_valid = state_q == OUT;
  assign res_op = res_op_q;
  assign res_data = res_data_q;
  assign err = err_q;
  assign m_STDW = stdw_q;
  assign m_STDR = stdr_q;
  assign m_STD_A = addr_q;
  assign m_weight_in = wdata_q;
  assign m_act_in = act_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      lat_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      act_q <= '0;
      stdw_q <= 1'b0;
      stdr_q <= 1'b0;
      err_q <= 1'b0;
      res_data_q <= '0;
      res_op_q <= '0;
    end else begin
      stdw_q <= w_hs;
      stdr_q <= 1'b0;
      err_q <= accept && cmd_op == 2'b11;
      if (w_hs) begin
        addr_q <= row_q;
        wdata_q <= w_data;
      end
      case (state_q)
        IDLE: if (accept) begin
          case (cmd_op)
            2'b00: state_q <= LOAD;
            2'b01: begin
              state_q <= COMP;
              act_q <= act_data;
              lat_q <= '0;
            end
            2'b10: begin
              state_q <= RBACK;
              stdr_q <= 1'b1;
              addr_q <= cmd_addr;
            end
            default: state_q <= IDLE;
          endcase
        end
        LOAD: if (w_valid) begin
          row_q <= last_row ? 6'd0 : row_q + 6'd1;
          state_q <= last_row ? IDLE : LOAD;
        end
        RBACK: begin
          res_data_q <= {80'd0, m_weight_out};
          res_op_q <= 2'b10;
          state_q <= OUT;
        end
        COMP: begin
          if (lat_q == 4'(MAC_LAT - 1)) begin
            res_data_q <= m_PSUM;
            res_op_q <= 2'b01;
            state_q <= OUT;
          end else lat_q <= lat_q + 4'd1;
        end
        OUT: if (res_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_macro_ctrl.sv
// tb_macro_ctrl: directed checks of macro_ctrl against a behavioural macro model.
module tb_macro_ctrl;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0;
  logic [5:0] cmd_addr = 0;
  logic w_valid = 0, w_ready;
  logic [31:0] w_data = 0;
  logic [255:0] act_data = 0;
  logic res_valid, res_ready = 0;
  logic [1:0] res_op;
  logic [111:0] res_data;
  logic busy, err, m_STDW, m_STDR;
  logic [5:0] m_STD_A;
  logic [31:0] m_weight_in, m_weight_out;
  logic [255:0] m_act_in;
  logic [111:0] m_PSUM;
  logic [31:0] mem [64];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  macro_ctrl #(.ROWS(64), .MAC_LAT(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .act_data(act_data), .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op),
    .res_data(res_data), .busy(busy), .err(err), .m_STDW(m_STDW), .m_STDR(m_STDR),
    .m_STD_A(m_STD_A), .m_weight_in(m_weight_in), .m_act_in(m_act_in),
    .m_weight_out(m_weight_out), .m_PSUM(m_PSUM)
  );
  // Macro model: synchronous row write, combinational row read, PSUM a fixed function of activations.
  always @(posedge clk) if (m_STDW) mem[m_STD_A] <= m_weight_in;
  assign m_weight_out = m_STDR ? mem[m_STD_A] : 32'hDEADBEEF;
  assign m_PSUM = m_act_in[111:0] ^ {14{8'hA5}};
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cmd(input logic [1:0] op, input logic [5:0] addr);
    cmd_valid = 1; cmd_op = op; cmd_addr = addr;
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic rb(input logic [5:0] addr, input logic [31:0] exp);
    cmd(2'b10, addr);
    chk("rb_stdr", m_STDR, 1);
    chk("rb_addr", m_STD_A, addr);
    chk("rb_stdw", m_STDW, 0);
    chk("rb_busy", busy, 1);
    @(negedge clk);
    chk("rb_stdr_off", m_STDR, 0);
    chk("rb_valid", res_valid, 1);
    chk("rb_data", res_data, {80'd0, exp});
    chk("rb_op", res_op, 2'b10);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("rb_done_valid", res_valid, 0);
    chk("rb_done_busy", busy, 0);
  endtask
  initial begin
    logic [111:0] held;
    int row;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_stdw", m_STDW, 0);
    chk("rst_stdr", m_STDR, 0);
    chk("rst_addr", m_STD_A, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_act", m_act_in, 0);
    rst = 0;
    @(negedge clk);
    // Load with w_valid held high.
    cmd(2'b00, 0);
    chk("ld_busy", busy, 1);
    chk("ld_w_ready", w_ready, 1);
    chk("ld_cmd_ready", cmd_ready, 0);
    chk("ld_stdw_pre", m_STDW, 0);
    w_valid = 1; w_data = 32'h01234567;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("ld_stdw", m_STDW, 1);
      chk("ld_addr", m_STD_A, i);
      chk("ld_wdata", m_weight_in, 32'h01234567);
      chk("ld_busy_run", busy, i < 63);
    end
    w_valid = 0;
    @(negedge clk);
    chk("ld_stdw_end", m_STDW, 0);
    chk("ld_addr_hold", m_STD_A, 63);
    chk("ld_wdata_hold", m_weight_in, 32'h01234567);
    rb(6'd35, 32'h01234567);
    // Load with w_valid toggling every other cycle.
    cmd(2'b00, 0);
    row = 0;
    for (int k = 0; k < 200 && row < 64; k++) begin
      w_valid = (k % 2 == 0);
      w_data = {row[7:0], 24'hC0FFEE};
      @(negedge clk);
      chk("tg_stdw", m_STDW, (k % 2 == 0));
      if (k % 2 == 0) begin
        chk("tg_addr", m_STD_A, row);
        chk("tg_wdata", m_weight_in, {row[7:0], 24'hC0FFEE});
        row++;
      end
      chk("tg_busy", busy, row < 64);
    end
    w_valid = 0;
    chk("tg_rows", row, 64);
    @(negedge clk);
    chk("tg_stdw_end", m_STDW, 0);
    rb(6'd35, 32'h23C0FFEE);
    // Compute with all-ones activations and a stalled result consumer.
    act_data = '1;
    cmd(2'b01, 0);
    act_data = '0;
    chk("cp_act", m_act_in, {256{1'b1}});
    chk("cp_busy", busy, 1);
    chk("cp_valid_early", res_valid, 0);
    chk("cp_stdw", m_STDW, 0);
    chk("cp_stdr", m_STDR, 0);
    @(negedge clk);
    chk("cp_valid", res_valid, 1);
    chk("cp_data", res_data, {14{8'h5A}});
    chk("cp_op", res_op, 2'b01);
    held = res_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cp_hold_valid", res_valid, 1);
      chk("cp_hold_data", res_data, held);
      chk("cp_hold_op", res_op, 2'b01);
      chk("cp_hold_act", m_act_in, {256{1'b1}});
      chk("cp_hold_cmd_ready", cmd_ready, 0);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("cp_idle", busy, 0);
    chk("cp_valid_off", res_valid, 0);
    // Reserved opcode.
    cmd(2'b11, 0);
    chk("rs_err", err, 1);
    chk("rs_busy", busy, 0);
    chk("rs_stdw", m_STDW, 0);
    chk("rs_stdr", m_STDR, 0);
    @(negedge clk);
    chk("rs_err_off", err, 0);
    // Reset in the middle of a load, then restart.
    cmd(2'b00, 0);
    w_valid = 1; w_data = 32'h55AA55AA;
    repeat (20) @(negedge clk);
    chk("mr_addr_pre", m_STD_A, 19);
    rst = 1; w_valid = 0;
    @(negedge clk);
    chk("mr_busy", busy, 0);
    chk("mr_stdw", m_STDW, 0);
    chk("mr_addr", m_STD_A, 0);
    chk("mr_w_ready", w_ready, 0);
    rst = 0;
    @(negedge clk);
    cmd(2'b00, 0);
    w_valid = 1;
    @(negedge clk);
    w_valid = 0;
    chk("mr_first_stdw", m_STDW, 1);
    chk("mr_first_addr", m_STD_A, 0);
    chk("mr_first_data", m_weight_in, 32'h55AA55AA);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/macro_ctrl.md
MACRO_CTRL -- requirements
Module: macro_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 64, number of macro weight rows loaded per load command.
REQ-002 SHALL have parameter MAC_LAT, default 1, cycles from act_in drive to PSUM capture (range 1..15).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_op in 2 (00 load, 01 compute, 10 readback, 11 reserved), cmd_addr in 6 (readback row).
REQ-006 SHALL have ports w_valid in 1, w_ready out 1, w_data in 32: weight row stream, 4b x 8.
REQ-007 SHALL have port act_data in 256, activations 4b x 64, sampled on compute-command accept.
REQ-008 SHALL have ports res_valid out 1, res_ready in 1, res_op out 2, res_data out 112: result channel.
REQ-009 SHALL have ports busy out 1 and err out 1.
REQ-010 SHALL have macro-side ports m_STDW out 1, m_STDR out 1, m_STD_A out 6, m_weight_in out 32, m_act_in out 256, m_weight_out in 32, m_PSUM in 112 (14b x 8).

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, RBACK, COMP, OUT; busy = (state != IDLE); cmd_ready = (state == IDLE).
REQ-012 SHALL accept a command when cmd_valid && cmd_ready; IDLE->LOAD (op 00), ->RBACK (10), ->COMP (01); op 11: stay IDLE, err = 1 for exactly one cycle.
REQ-013 SHALL, in LOAD, assert w_ready; w_ready SHALL be 0 in every other state and w_valid is then ignored.
REQ-014 SHALL, for each w handshake at cycle t with row counter r, drive m_STDW=1, m_STD_A=r, m_weight_in=w_data during cycle t+1 only; m_STDW=0 in cycles without a handshake in cycle t-1.
REQ-015 SHALL increment row counter per handshake, wrap ROWS-1 -> 0, and go LOAD->IDLE in the cycle after the handshake for row ROWS-1 (the final write is still issued).
REQ-016 SHALL, in RBACK, drive m_STDR=1, m_STD_A=cmd_addr for the first RBACK cycle, capture m_weight_out into res_data[31:0] (res_data[111:32]=0) on the following edge, res_op=10, then go to OUT.
REQ-017 SHALL, on compute accept, register act_data into m_act_in and hold it until the next compute accept; m_STDW=m_STDR=0 throughout COMP.
REQ-018 SHALL capture m_PSUM into res_data on the MAC_LAT-th edge after m_act_in updates, res_op=01, then go to OUT.
REQ-019 SHALL, in OUT, hold res_valid=1 and res_data/res_op stable until res_valid && res_ready, then go to IDLE; res_valid=0 in all other states.
REQ-020 SHALL never assert m_STDW and m_STDR in the same cycle.
REQ-021 SHALL keep m_STD_A and m_weight_in at their last driven values when the strobes are 0.

Reset
REQ-022 SHALL, while rst=1, force state IDLE, row counter 0, MAC_LAT counter 0, m_STDW=m_STDR=0, m_STD_A=0, m_weight_in=0, m_act_in=0, res_valid=0, res_data=0, res_op=0, err=0, busy=0, w_ready=0, cmd_ready=1.
REQ-023 SHALL abandon any partial load, readback or compute on reset; the next load restarts at row 0; macro array contents are not cleared.

Verification
REQ-024 SHALL be verified: load cmd + 64 rows of w_data=32'h01234567 with w_valid held -> 64 consecutive m_STDW pulses, m_STD_A 0..63, busy falls in the cycle after the last write.
REQ-025 SHALL be verified: load with w_valid toggling every other cycle -> m_STDW only in cycles after handshakes, addresses still contiguous 0..63.
REQ-026 SHALL be verified: readback cmd_addr=35 after the load -> one m_STDR cycle with m_STD_A=35; res_data=112'h01234567, res_op=10.
REQ-027 SHALL be verified: compute with act_data all ones, MAC_LAT=1, res_ready held 0 for 5 cycles -> res_data equals m_PSUM sampled one cycle after m_act_in update, held stable; IDLE the cycle after res_ready=1.
REQ-028 SHALL be verified: cmd_op=11 -> single-cycle err, no macro strobe; rst asserted at row 20 of a load, then a new load -> first write at m_STD_A=0.
